// File: rtl/cordic_iq2phase.sv
// cordic_iq2phase: recovers phase, magnitude and per-sample phase increment
// from an interleaved 24-bit I/Q word stream using a fully pipelined
// vectoring-mode CORDIC (one iteration per stage, single clock dclk).
// Phase units match the dds2k24 frequency word: 2^32 = one full turn.
module cordic_iq2phase #(
    parameter int ITER = 24
) (
    input  logic        dclk,
    input  logic        rst,
    input  logic [23:0] dixy,
    input  logic        iq,
    output logic [31:0] phs,
    output logic [24:0] mag,
    output logic [31:0] frq,
    output logic        vld,
    output logic        fv
);

    // Fractional guard bits below the 26-bit integer datapath keep the
    // truncation error of the shifted add/subtract chain well below one LSB.
    localparam int GUARD = 6;
    localparam int XW    = 26 + GUARD;

    // Elementary rotation angles round(atan(2^-k) * 2^32 / 2pi).
    function automatic logic [31:0] atanTab(input int k);
        case (k)
            0:       return 32'h2000_0000;
            1:       return 32'h12E4_051E;
            2:       return 32'h09FB_385B;
            3:       return 32'h0511_11D4;
            4:       return 32'h028B_0D43;
            5:       return 32'h0145_D7E1;
            6:       return 32'h00A2_F61E;
            7:       return 32'h0051_7C55;
            8:       return 32'h0028_BE53;
            9:       return 32'h0014_5F2F;
            10:      return 32'h000A_2F98;
            11:      return 32'h0005_17CC;
            12:      return 32'h0002_8BE6;
            13:      return 32'h0001_45F3;
            14:      return 32'h0000_A2FA;
            15:      return 32'h0000_517D;
            16:      return 32'h0000_28BE;
            17:      return 32'h0000_145F;
            18:      return 32'h0000_0A30;
            19:      return 32'h0000_0518;
            20:      return 32'h0000_028C;
            21:      return 32'h0000_0146;
            22:      return 32'h0000_00A3;
            23:      return 32'h0000_0051;
            24:      return 32'h0000_0029;
            25:      return 32'h0000_0014;
            26:      return 32'h0000_000A;
            27:      return 32'h0000_0005;
            28:      return 32'h0000_0003;
            29:      return 32'h0000_0001;
            default: return 32'h0000_0000;
        endcase
    endfunction

    logic [23:0] iLatch_q;
    logic        iHeld_q;
    logic [23:0] pairI_q;
    logic [23:0] pairQ_q;
    logic        pairV_q;

    // Pairing: hold the latest I word, launch {I, Q} when a Q follows it.
    always_ff @(posedge dclk) begin
        if (rst) begin
            iLatch_q <= 24'h0;
            iHeld_q  <= 1'b0;
            pairV_q  <= 1'b0;
        end else begin
            pairV_q <= 1'b0;
            if (iq) begin
                iLatch_q <= dixy;
                iHeld_q  <= 1'b1;
            end else if (iHeld_q) begin
                pairI_q <= iLatch_q;
                pairQ_q <= dixy;
                pairV_q <= 1'b1;
                iHeld_q <= 1'b0;
            end
        end
    end

    logic signed [XW-1:0] iExt;
    logic signed [XW-1:0] qExt;
    logic signed [XW-1:0] preX_d;
    logic signed [XW-1:0] preY_d;
    logic        [31:0]   preZ_d;
    logic                 preZero_d;

    assign iExt = {{(XW-24-GUARD){pairI_q[23]}}, pairI_q, {GUARD{1'b0}}};
    assign qExt = {{(XW-24-GUARD){pairQ_q[23]}}, pairQ_q, {GUARD{1'b0}}};

    // Pre-rotation folds the left half-plane onto the right by 180 degrees.
    always_comb begin
        preX_d = iExt;
        preY_d = qExt;
        preZ_d = 32'h0000_0000;
        if (pairI_q[23]) begin
            preX_d = -iExt;
            preY_d = -qExt;
            preZ_d = 32'h8000_0000;
        end
        preZero_d = (pairI_q == 24'h0) && (pairQ_q == 24'h0);
    end

    logic signed [XW-1:0] x_q  [0:ITER];
    logic signed [XW-1:0] y_q  [0:ITER];
    logic        [31:0]   z_q  [0:ITER];
    logic                 v_q  [0:ITER];
    logic                 zf_q [0:ITER];

    logic signed [XW-1:0] x_d [0:ITER-1];
    logic signed [XW-1:0] y_d [0:ITER-1];
    logic        [31:0]   z_d [0:ITER-1];

    // CORDIC iterations: rotate toward y=0, accumulating the applied angle.
    always_comb begin
        for (int k = 0; k < ITER; k++) begin
            x_d[k] = x_q[k];
            y_d[k] = y_q[k];
            z_d[k] = z_q[k];
            if (!y_q[k][XW-1]) begin
                x_d[k] = x_q[k] + (y_q[k] >>> k);
                y_d[k] = y_q[k] - (x_q[k] >>> k);
                z_d[k] = z_q[k] + atanTab(k);
            end else begin
                x_d[k] = x_q[k] - (y_q[k] >>> k);
                y_d[k] = y_q[k] + (x_q[k] >>> k);
                z_d[k] = z_q[k] - atanTab(k);
            end
        end
    end

    // Pipeline registers; only the valid bits need clearing on reset.
    always_ff @(posedge dclk) begin
        if (rst) begin
            for (int k = 0; k <= ITER; k++) begin
                v_q[k] <= 1'b0;
            end
        end else begin
            v_q[0]  <= pairV_q;
            x_q[0]  <= preX_d;
            y_q[0]  <= preY_d;
            z_q[0]  <= preZ_d;
            zf_q[0] <= preZero_d;
            for (int k = 0; k < ITER; k++) begin
                v_q[k+1]  <= v_q[k];
                x_q[k+1]  <= x_d[k];
                y_q[k+1]  <= y_d[k];
                z_q[k+1]  <= z_d[k];
                zf_q[k+1] <= zf_q[k];
            end
        end
    end

    logic [31:0] outPhs_d;
    logic [24:0] outMag_d;
    logic        unusedBits;

    // The residual y and the bits of x outside the magnitude field are not needed.
    assign unusedBits = ^{y_q[ITER], x_q[ITER][XW-1:GUARD+25], x_q[ITER][GUARD-1:0]};

    // Output selection; an all-zero input has no defined angle and reports zero.
    always_comb begin
        outPhs_d = z_q[ITER];
        outMag_d = x_q[ITER][GUARD+24:GUARD];
        if (zf_q[ITER]) begin
            outPhs_d = 32'h0000_0000;
            outMag_d = 25'h0;
        end
    end

    logic [31:0] phs_q;
    logic [24:0] mag_q;
    logic [31:0] frq_q;
    logic        vld_q;
    logic        fv_q;
    logic        prevValid_q;

    // Output register; phs_q doubles as the previous phase for the increment.
    always_ff @(posedge dclk) begin
        if (rst) begin
            phs_q       <= 32'h0;
            mag_q       <= 25'h0;
            frq_q       <= 32'h0;
            vld_q       <= 1'b0;
            fv_q        <= 1'b0;
            prevValid_q <= 1'b0;
        end else begin
            vld_q <= v_q[ITER];
            fv_q  <= v_q[ITER] && prevValid_q;
            if (v_q[ITER]) begin
                phs_q       <= outPhs_d;
                mag_q       <= outMag_d;
                frq_q       <= prevValid_q ? (outPhs_d - phs_q) : 32'h0;
                prevValid_q <= 1'b1;
            end
        end
    end

    assign phs = phs_q;
    assign mag = mag_q;
    assign frq = frq_q;
    assign vld = vld_q;
    assign fv  = fv_q;

endmodule

// File: tb/tb_cordic_iq2phase.sv
// Testbench for cordic_iq2phase: directed I/Q vectors with hand-computed
// phase/magnitude expectations, pairing rules, reset behaviour and a
// synthesized-tone loopback checking the recovered phase increment.
module tb_cordic_iq2phase;

    localparam int  ITER = 24;
    localparam int  LAT  = ITER + 2;
    localparam real AMP  = 6000000.0;
    localparam real TWOPI = 6.283185307179586;

    logic        dclk = 1'b0;
    logic        rst;
    logic [23:0] dixy;
    logic        iq;
    logic [31:0] phs;
    logic [24:0] mag;
    logic [31:0] frq;
    logic        vld;
    logic        fv;

    int compared   = 0;
    int mismatched = 0;

    cordic_iq2phase #(.ITER(ITER)) dut (
        .dclk (dclk),
        .rst  (rst),
        .dixy (dixy),
        .iq   (iq),
        .phs  (phs),
        .mag  (mag),
        .frq  (frq),
        .vld  (vld),
        .fv   (fv)
    );

    // Free-running word-rate clock
    always #5 dclk = ~dclk;

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    function automatic int absDiff(input logic [31:0] a, input logic [31:0] b);
        int d;
        d = int'(a - b);
        return (d < 0) ? -d : d;
    endfunction

    function automatic int magDiff(input logic [24:0] a, input int b);
        int d;
        d = int'({7'h0, a}) - b;
        return (d < 0) ? -d : d;
    endfunction

    task automatic sendPair(input logic [23:0] iv, input logic [23:0] qv);
        iq   = 1'b1;
        dixy = iv;
        tick();
        iq   = 1'b0;
        dixy = qv;
        tick();
        dixy = 24'h0;
    endtask

    task automatic waitVld(output int lat);
        lat = -1;
        for (int k = 1; k <= LAT + 4; k++) begin
            tick();
            if (vld === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            iq   = i[0];
            dixy = 24'($urandom);
            tick();
            compared++;
            if (vld !== 1'b0 || fv !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL resetStrobes: vld=%b fv=%b, required 0 0", vld, fv);
            end
        end
        compared++;
        if (phs !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL resetPhs: got %h, required 0", phs);
        end
        compared++;
        if (mag !== 25'h0) begin
            mismatched++;
            $display("[TB] FAIL resetMag: got %h, required 0", mag);
        end
        compared++;
        if (frq !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL resetFrq: got %h, required 0", frq);
        end
        iq   = 1'b0;
        dixy = 24'h0;
        rst  = 1'b0;
        tick();
    endtask

    task automatic test_reset_midflight();
        int lat;
        int cnt;
        sendPair(24'h400000, 24'h000000);
        waitVld(lat);
        compared++;
        if (lat != LAT) begin
            mismatched++;
            $display("[TB] FAIL preResetLatency: got %0d, required %0d", lat, LAT);
        end
        sendPair(24'h000000, 24'h400000);
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            tick();
            if (vld === 1'b1) cnt++;
        end
        compared++;
        if (cnt != 0) begin
            mismatched++;
            $display("[TB] FAIL midResetFlush: got %0d strobes, required 0", cnt);
        end
    endtask

    task automatic test_cardinal();
        logic [23:0] iv [4];
        logic [23:0] qv [4];
        logic [31:0] ph [4];
        logic [31:0] step;
        int lat;
        iv = '{24'h400000, 24'h000000, 24'hC00000, 24'h000000};
        qv = '{24'h000000, 24'h400000, 24'h000000, 24'hC00000};
        ph = '{32'h00000000, 32'h40000000, 32'h80000000, 32'hC0000000};
        for (int i = 0; i < 4; i++) begin
            sendPair(iv[i], qv[i]);
            waitVld(lat);
            compared++;
            if (lat != LAT) begin
                mismatched++;
                $display("[TB] FAIL cardLatency[%0d]: got %0d, required %0d", i, lat, LAT);
            end
            compared++;
            if (absDiff(phs, ph[i]) > 1024) begin
                mismatched++;
                $display("[TB] FAIL cardPhs[%0d]: got %h, required %h +-1024", i, phs, ph[i]);
            end
            compared++;
            if (magDiff(mag, 6907050) > 700) begin
                mismatched++;
                $display("[TB] FAIL cardMag[%0d]: got %0d, required 6907050 +-700", i, mag);
            end
            if (i == 0) begin
                compared++;
                if (fv !== 1'b0 || frq !== 32'h0) begin
                    mismatched++;
                    $display("[TB] FAIL firstFv: fv=%b frq=%h, required 0 0", fv, frq);
                end
            end else begin
                step = ph[i] - ph[i-1];
                compared++;
                if (fv !== 1'b1 || absDiff(frq, step) > 2048) begin
                    mismatched++;
                    $display("[TB] FAIL cardFrq[%0d]: fv=%b frq=%h, required 1 %h", i, fv, frq, step);
                end
            end
            tick();
            compared++;
            if (vld !== 1'b0 || absDiff(phs, ph[i]) > 1024) begin
                mismatched++;
                $display("[TB] FAIL cardHold[%0d]: vld=%b phs=%h, required 0 %h", i, vld, phs, ph[i]);
            end
        end
    endtask

    task automatic test_diag45_zero();
        int lat;
        sendPair(24'h300000, 24'h300000);
        waitVld(lat);
        compared++;
        if (lat != LAT || absDiff(phs, 32'h20000000) > 1024) begin
            mismatched++;
            $display("[TB] FAIL diagPhs: lat=%0d phs=%h, required %0d 20000000", lat, phs, LAT);
        end
        compared++;
        if (magDiff(mag, 7325993) > 733) begin
            mismatched++;
            $display("[TB] FAIL diagMag: got %0d, required 7325993 +-733", mag);
        end
        sendPair(24'h000000, 24'h000000);
        waitVld(lat);
        compared++;
        if (lat != LAT) begin
            mismatched++;
            $display("[TB] FAIL zeroLatency: got %0d, required %0d", lat, LAT);
        end
        compared++;
        if (phs !== 32'h0 || mag !== 25'h0) begin
            mismatched++;
            $display("[TB] FAIL zeroOut: phs=%h mag=%h, required 0 0", phs, mag);
        end
        compared++;
        if (fv !== 1'b1 || absDiff(frq, 32'hE0000000) > 1024) begin
            mismatched++;
            $display("[TB] FAIL zeroFrq: fv=%b frq=%h, required 1 E0000000", fv, frq);
        end
    endtask

    task automatic test_pairing();
        int lat;
        int cnt;
        iq   = 1'b1;
        dixy = 24'h400000;
        tick();
        dixy = 24'hC00000;
        tick();
        iq   = 1'b0;
        dixy = 24'h000000;
        tick();
        waitVld(lat);
        compared++;
        if (lat != LAT) begin
            mismatched++;
            $display("[TB] FAIL iiqLatency: got %0d, required %0d", lat, LAT);
        end
        compared++;
        if (absDiff(phs, 32'h80000000) > 1024 || magDiff(mag, 6907050) > 700) begin
            mismatched++;
            $display("[TB] FAIL iiqReplace: phs=%h mag=%0d, required 80000000 6907050", phs, mag);
        end
        cnt = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            dixy = (k < 3) ? 24'h200000 : 24'h000000;
            tick();
            if (vld === 1'b1) cnt++;
        end
        compared++;
        if (cnt != 0) begin
            mismatched++;
            $display("[TB] FAIL loneQ: got %0d strobes, required 0", cnt);
        end
        dixy = 24'h0;
    endtask

    task automatic test_loopback(input string name, input logic [31:0] phase0,
                                 input logic [31:0] step, input int n);
        logic [31:0] ph;
        logic [31:0] expPh;
        real         ang;
        int          iVal;
        int          qVal;
        int          outCount;
        int          lastT;
        qVal = 0;
        rst  = 1'b1;
        iq   = 1'b0;
        dixy = 24'h0;
        tick();
        rst      = 1'b0;
        outCount = 0;
        lastT    = -1;
        for (int t = 0; t < 2 * n + LAT + 6; t++) begin
            if (t < 2 * n) begin
                if (t % 2 == 0) begin
                    ph   = phase0 + 32'(t / 2) * step;
                    ang  = TWOPI * real'(ph) / 4294967296.0;
                    iVal = int'(AMP * $cos(ang));
                    qVal = int'(AMP * $sin(ang));
                    iq   = 1'b1;
                    dixy = 24'(iVal);
                end else begin
                    iq   = 1'b0;
                    dixy = 24'(qVal);
                end
            end else begin
                iq   = 1'b0;
                dixy = 24'h0;
            end
            tick();
            if (vld === 1'b1) begin
                expPh = phase0 + 32'(outCount) * step;
                compared++;
                if (absDiff(phs, expPh) > 1024) begin
                    mismatched++;
                    $display("[TB] FAIL %s phs[%0d]: got %h, required %h +-1024", name, outCount, phs, expPh);
                end
                compared++;
                if (magDiff(mag, 9880562) > 1200) begin
                    mismatched++;
                    $display("[TB] FAIL %s mag[%0d]: got %0d, required 9880562 +-1200", name, outCount, mag);
                end
                if (outCount == 0) begin
                    compared++;
                    if (fv !== 1'b0 || frq !== 32'h0) begin
                        mismatched++;
                        $display("[TB] FAIL %s firstFv: fv=%b frq=%h, required 0 0", name, fv, frq);
                    end
                    compared++;
                    if (t != 1 + LAT) begin
                        mismatched++;
                        $display("[TB] FAIL %s firstLatency: got %0d, required %0d", name, t - 1, LAT);
                    end
                end else begin
                    compared++;
                    if (fv !== 1'b1 || absDiff(frq, step) > 1024) begin
                        mismatched++;
                        $display("[TB] FAIL %s frq[%0d]: fv=%b frq=%h, required 1 %h", name, outCount, fv, frq, step);
                    end
                    compared++;
                    if (t - lastT != 2) begin
                        mismatched++;
                        $display("[TB] FAIL %s gap[%0d]: got %0d, required 2", name, outCount, t - lastT);
                    end
                end
                lastT = t;
                outCount++;
            end else if (outCount > 0) begin
                expPh = phase0 + 32'(outCount - 1) * step;
                compared++;
                if (fv !== 1'b0 || absDiff(phs, expPh) > 1024) begin
                    mismatched++;
                    $display("[TB] FAIL %s hold: fv=%b phs=%h, required 0 %h", name, fv, phs, expPh);
                end
            end
        end
        compared++;
        if (outCount != n) begin
            mismatched++;
            $display("[TB] FAIL %s count: got %0d, required %0d", name, outCount, n);
        end
    endtask

    // Test sequence
    initial begin
        rst  = 1'b1;
        iq   = 1'b0;
        dixy = 24'h0;
        $display("[TB] start, ITER=%0d", ITER);
        test_reset();
        test_reset_midflight();
        test_cardinal();
        test_diag45_zero();
        test_pairing();
        test_loopback("loopPos", 32'hFFC00000, 32'h00010000, 8192);
        test_loopback("loopNeg", 32'h00100000, 32'hFFFF0000, 512);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
